// File: rtl/rom_reader_pkg.sv
// Shared types and default geometry for the rom sweep reader and its rom block.
package rom_reader_pkg;
  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 4;
  localparam int ROM_RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;
endpackage

// File: rtl/rom_reader_if.sv
// Rom read port plus downstream valid/ready word stream.
interface rom_reader_if
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic              rom_read;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output rom_read, rom_address, out_valid, out_data, out_addr, out_last,
    input  rom_data, out_ready
  );
  modport slave (
    input  rom_read, rom_address, out_valid, out_data, out_addr, out_last,
    output rom_data, out_ready
  );
endinterface

// File: rtl/rom_rd_lat_cnt.sv
// Loadable down-counter; expire marks the edge on which rom data is valid.
module rom_rd_lat_cnt
  import rom_reader_pkg::*;
#(
  parameter int RD_LAT = ROM_RD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= CW'(RD_LAT);
    else if (en && cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign expire = en && (cnt == CW'(1));
endmodule

// File: rtl/rom_reader.sv
// Walks an inclusive (wrapping) rom address range, streams each word out
// on valid/ready and accumulates a checksum of the sweep.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int RD_LAT = ROM_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  rom_reader_if.master             bus,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W+DATA_W-1:0] checksum
);
  localparam int CSW = ADDR_W + DATA_W;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last;
  logic              lat_expire;

  rom_rd_lat_cnt #(.RD_LAT(RD_LAT)) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ISSUE),
    .en     (state == WAIT),
    .expire (lat_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      addr            <= '0;
      last            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      checksum        <= '0;
      bus.rom_read    <= 1'b0;
      bus.rom_address <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_addr    <= '0;
      bus.out_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr            <= start_addr;
          last            <= last_addr;
          checksum        <= '0;
          busy            <= 1'b1;
          bus.rom_read    <= 1'b1;
          bus.rom_address <= start_addr;
          state           <= ISSUE;
        end
        ISSUE: begin
          bus.rom_read <= 1'b0;
          state        <= WAIT;
        end
        WAIT: if (lat_expire) begin
          bus.out_data  <= bus.rom_data;
          bus.out_addr  <= addr;
          bus.out_last  <= (addr == last);
          bus.out_valid <= 1'b1;
          checksum      <= checksum + CSW'(bus.rom_data);
          state         <= PUSH;
        end
        PUSH: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (bus.out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // wraps naturally through 0 for last_addr < start_addr
            addr            <= addr + ADDR_W'(1);
            bus.rom_address <= addr + ADDR_W'(1);
            bus.rom_read    <= 1'b1;
            state           <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader against a 1-cycle-latency rom holding a ^ 5.
module tb_rom_reader;
  import rom_reader_pkg::*;
  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy, done;
  logic [AW+DW-1:0] checksum;

  rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  rom_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .last_addr  (last_addr),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  initial for (int a = 0; a < 16; a++) mem[a] = DW'(a) ^ 4'h5;

  always @(posedge clk) if (bus.rom_read) bus.rom_data <= mem[bus.rom_address];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t            wq[$];
  logic [AW+DW-1:0] csq[$];
  int errors = 0;
  int checks = 0;
  int words_seen = 0;
  int rdy_mode = 0;
  int stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word count from modular distance, data straight from rom contents.
  task automatic push_sweep(input logic [AW-1:0] s, input logic [AW-1:0] l);
    int n;
    logic [AW+DW-1:0] sum;
    logic [AW-1:0] a;
    n   = int'(AW'(l - s)) + 1;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'(int'(s) + i);
      wq.push_back('{a: a, d: mem[a], l: (i == n - 1)});
      sum += (AW+DW)'(mem[a]);
    end
    csq.push_back(sum);
  endtask

  task automatic start_sweep(input logic [AW-1:0] s, input logic [AW-1:0] l);
    int t = 0;
    @(posedge clk); #1;
    while (busy !== 1'b0 && t < 2000) begin @(posedge clk); #1; t++; end
    if (t >= 2000) chk("start_wait_timeout", 1, 0);
    start = 1'b1; start_addr = s; last_addr = l;
    @(posedge clk);
    push_sweep(s, l);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (cyc > 2000) begin chk("done_timeout", 1, 0); break; end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.rom_read, bus.rom_address, bus.out_valid, bus.out_data, bus.out_addr,
               bus.out_last, busy, done, checksum}, 0);
  endtask

  // downstream ready generator
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default:
          if (bus.out_valid && words_seen == 2 && stall < 10) begin
            bus.out_ready = 1'b0; stall++;
          end else bus.out_ready = 1'b1;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic pv, pr, pl;
    logic [AW-1:0] pa, pra;
    logic [DW-1:0] pd;
    word_t w;
    pv = 0; pr = 0; pl = 0; pa = '0; pra = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 0; words_seen = 0;
      end else begin
        if (bus.out_valid) chk("rom_read_while_valid", 32'(bus.rom_read), 0);
        if (pv && !pr) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_word", {bus.out_addr, bus.out_data, bus.out_last}, {pa, pd, pl});
          chk("hold_rom_address", 32'(bus.rom_address), 32'(pra));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (wq.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            w = wq.pop_front();
            chk("word", {bus.out_addr, bus.out_data, bus.out_last}, {w.a, w.d, w.l});
            words_seen++;
          end
        end
        if (done) begin
          chk("done_busy_low", 32'(busy), 0);
          if (csq.size() == 0) chk("unexpected_done", 1, 0);
          else chk("checksum", 32'(checksum), 32'(csq.pop_front()));
          chk("words_left_at_done", wq.size(), 0);
          words_seen = 0;
        end
        pv = bus.out_valid; pr = bus.out_ready;
        pa = bus.out_addr; pd = bus.out_data; pl = bus.out_last; pra = bus.rom_address;
      end
    end
  end

  initial begin
    int c, t;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset_state");
    rst = 1'b1;

    // full sweep, 3 cycles per word with ready held
    rdy_mode = 0;
    start_sweep(0, 15);
    wait_done(c);
    chk("full_cycles", c, 48);
    chk("full_checksum", 32'(checksum), 32'h78);

    // wrap through 0
    start_sweep(14, 1);
    wait_done(c);
    chk("wrap_checksum", 32'(checksum), 32'h1E);

    // 10-cycle stall on the third word
    rdy_mode = 2; stall = 0;
    start_sweep(0, 5);
    wait_done(c);
    chk("stall_cycles", stall, 10);
    rdy_mode = 0;

    // single word
    start_sweep(7, 7);
    wait_done(c);
    chk("single_cycles", c, 3);
    chk("single_checksum", 32'(checksum), 32'h02);

    // reset while word 5 is presented
    start_sweep(0, 15);
    t = 0;
    @(posedge clk); #1;
    while (!(words_seen == 4 && bus.out_valid) && t < 500) begin @(posedge clk); #1; t++; end
    chk("word5_reached", 32'(t < 500), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midsweep_reset");
    wq.delete(); csq.delete();
    rst = 1'b1;
    repeat (5) begin @(negedge clk); chk("no_done_after_reset", 32'(done), 0); end
    start_sweep(3, 9);
    wait_done(c);

    // start pulse while busy ignored; start held into done cycle accepted
    rdy_mode = 1;
    start_sweep(2, 6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; start_addr = 0; last_addr = 0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; start_addr = 9; last_addr = 12;
    wait_done(c);
    @(posedge clk);
    push_sweep(9, 12);
    #1 chk("busy_after_done_start", 32'(busy), 1);
    start = 1'b0;
    wait_done(c);

    // random ranges with random backpressure
    for (int i = 0; i < 8; i++) begin
      start_sweep(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
      wait_done(c);
    end

    repeat (3) @(posedge clk);
    chk("final_word_queue", wq.size(), 0);
    chk("final_checksum_queue", csq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
